// File: rtl/sipo_receiver.sv
// sipo_receiver: serial-in parallel-out word receiver, MSB first,
// with a one-word holding register, valid/ready handoff and sticky overrun.
module sipo_receiver #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             serial_in,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);

    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_ovr;

    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_done;
    logic             w_free;
    logic             w_consume;

    assign w_word    = {r_sreg[WIDTH-2:0], serial_in};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_done    = shift & ~clear & w_last;
    assign w_free    = ~r_valid | data_ready;
    assign w_consume = r_valid & data_ready;

    // Shift register, bit counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_ovr  <= 1'b0;
        end else if (clear) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_ovr  <= 1'b0;
        end else if (shift) begin
            r_sreg <= w_word;
            if (w_last) begin
                r_cnt <= '0;
                if (!w_free) begin
                    r_ovr <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Holding register: load a completed word when free, else drain on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_done && w_free) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign bit_count  = r_cnt;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_sipo_receiver.sv
// tb_sipo_receiver: directed self-checking bench for sipo_receiver
// at WIDTH=4 with hand-computed expected values.
module tb_sipo_receiver;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       shift;
    logic       serial_in;
    logic       data_ready;
    logic [3:0] data_out;
    logic       data_valid;
    logic [1:0] bit_count;
    logic       overrun;

    int n_checks;
    int n_fail;

    sipo_receiver #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .shift      (shift),
        .serial_in  (serial_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one shift edge carrying bit b, with data_ready=rdy on that edge
    task automatic send_bit(input logic b, input logic rdy);
        shift      = 1'b1;
        serial_in  = b;
        data_ready = rdy;
        tick();
        shift      = 1'b0;
        data_ready = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i], (i == 0) ? rdy_last : 1'b0);
        end
    endtask

    task automatic consume();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] pat;
        logic [1:0] exp_bc [4];
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        clear      = 1'b0;
        shift      = 1'b0;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_bc", 32'(bit_count), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);

        // idle: toggling serial_in with shift=0, ready while empty
        for (int i = 0; i < 4; i++) begin
            serial_in  = ~serial_in;
            data_ready = i[0];
            tick();
        end
        data_ready = 1'b0;
        chk("idle_bc", 32'(bit_count), 32'h0);
        chk("idle_valid", 32'(data_valid), 32'h0);
        chk("idle_data", 32'(data_out), 32'h0);

        // basic receive 1,0,1,1
        pat = 4'b1011;
        exp_bc = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            send_bit(pat[3 - i], 1'b0);
            chk($sformatf("rx_bc%0d", i), 32'(bit_count),
                32'(exp_bc[i]));
            if (i < 3) chk($sformatf("rx_nv%0d", i), 32'(data_valid), 32'h0);
        end
        chk("rx_data", 32'(data_out), 32'hB);
        chk("rx_valid", 32'(data_valid), 32'h1);

        // handshake
        consume();
        chk("hs_valid", 32'(data_valid), 32'h0);
        chk("hs_data", 32'(data_out), 32'hB);
        chk("hs_ovr", 32'(overrun), 32'h0);

        // overrun: 1011 held, 0110 arrives with no ready
        send_word(4'b1011, 1'b0);
        chk("ov_pre_valid", 32'(data_valid), 32'h1);
        send_word(4'b0110, 1'b0);
        chk("ov_flag", 32'(overrun), 32'h1);
        chk("ov_data", 32'(data_out), 32'hB);
        chk("ov_valid", 32'(data_valid), 32'h1);
        consume();
        chk("ov_sticky", 32'(overrun), 32'h1);
        chk("ov_drain", 32'(data_valid), 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ov_clr", 32'(overrun), 32'h0);
        chk("ov_clr_data", 32'(data_out), 32'hB);

        // back-to-back: last bit of 0110 meets ready while 1011 valid
        send_word(4'b1011, 1'b0);
        send_word(4'b0110, 1'b1);
        chk("b2b_data", 32'(data_out), 32'h6);
        chk("b2b_valid", 32'(data_valid), 32'h1);
        chk("b2b_ovr", 32'(overrun), 32'h0);
        consume();
        chk("b2b_drain", 32'(data_valid), 32'h0);

        // mid-word abort with clear colliding with shift
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("ab_bc2", 32'(bit_count), 32'h2);
        clear     = 1'b1;
        shift     = 1'b1;
        serial_in = 1'b1;
        tick();
        clear = 1'b0;
        shift = 1'b0;
        chk("ab_bc", 32'(bit_count), 32'h0);
        chk("ab_valid", 32'(data_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("ab_bc3", 32'(bit_count), 32'h3);
        chk("ab_nword", 32'(data_valid), 32'h0);

        // rst mid-word
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_data", 32'(data_out), 32'h0);
        chk("mr_valid", 32'(data_valid), 32'h0);
        chk("mr_bc", 32'(bit_count), 32'h0);
        chk("mr_ovr", 32'(overrun), 32'h0);
        send_word(4'b1100, 1'b0);
        chk("mr_word", 32'(data_out), 32'hC);
        chk("mr_wvalid", 32'(data_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
